// File: rtl/aeolus_display_pkg.sv
// Shared state type, digit count, glyph table and BCD helper for the display driver.
package aeolus_display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD3  = 2'd1,
    SHIFT = 2'd2,
    LATCH = 2'd3
  } conv_state_t;

  localparam int NUM_DIGITS = 4;
  localparam int BCD_W      = 4 * NUM_DIGITS;

  // Glyphs are {g,f,e,d,c,b,a}, active-high; output polarity is applied at the pins.
  localparam logic [6:0] GLYPH_0     = 7'h3F;
  localparam logic [6:0] GLYPH_1     = 7'h06;
  localparam logic [6:0] GLYPH_2     = 7'h5B;
  localparam logic [6:0] GLYPH_3     = 7'h4F;
  localparam logic [6:0] GLYPH_4     = 7'h66;
  localparam logic [6:0] GLYPH_5     = 7'h6D;
  localparam logic [6:0] GLYPH_6     = 7'h7D;
  localparam logic [6:0] GLYPH_7     = 7'h07;
  localparam logic [6:0] GLYPH_8     = 7'h7F;
  localparam logic [6:0] GLYPH_9     = 7'h6F;
  localparam logic [6:0] GLYPH_A     = 7'h77;
  localparam logic [6:0] GLYPH_B     = 7'h7C;
  localparam logic [6:0] GLYPH_C     = 7'h39;
  localparam logic [6:0] GLYPH_D     = 7'h5E;
  localparam logic [6:0] GLYPH_E     = 7'h79;
  localparam logic [6:0] GLYPH_F     = 7'h71;
  localparam logic [6:0] GLYPH_BLANK = 7'h00;

  function automatic logic [BCD_W-1:0] bcd_add3(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] res;
    res = bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end else begin
        res[4*i +: 4] = bcd[4*i +: 4];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/seg_decoder.sv
// Combinational nibble-to-glyph decoder with blanking; output is active-high.
module seg_decoder
  import aeolus_display_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = GLYPH_BLANK;
    if (blank) begin
      seg = GLYPH_BLANK;
    end else begin
      case (nibble)
        4'h0:    seg = GLYPH_0;
        4'h1:    seg = GLYPH_1;
        4'h2:    seg = GLYPH_2;
        4'h3:    seg = GLYPH_3;
        4'h4:    seg = GLYPH_4;
        4'h5:    seg = GLYPH_5;
        4'h6:    seg = GLYPH_6;
        4'h7:    seg = GLYPH_7;
        4'h8:    seg = GLYPH_8;
        4'h9:    seg = GLYPH_9;
        4'hA:    seg = GLYPH_A;
        4'hB:    seg = GLYPH_B;
        4'hC:    seg = GLYPH_C;
        4'hD:    seg = GLYPH_D;
        4'hE:    seg = GLYPH_E;
        4'hF:    seg = GLYPH_F;
        default: seg = GLYPH_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/seven_seg_driver.sv
// Four-digit multiplexed seven-segment driver. Hex display by default;
// define SEVEN_SEG_DECIMAL_EN for decimal display via a double-dabble FSM.
module seven_seg_driver
  import aeolus_display_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int REFRESH_TARGET = 1000,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] dataIn,
  output logic [6:0]            segOut,
  output logic [3:0]            anodeOut,
  output logic                  busy
);

  localparam int REF_W = (REFRESH_TARGET > 1) ? $clog2(REFRESH_TARGET) : 1;
  localparam logic [6:0] SEG_MASK   = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [3:0] ANODE_MASK = (SEG_ACTIVE_LOW != 0) ? 4'hF : 4'h0;

  conv_state_t           state, state_next;
  logic [DATA_WIDTH-1:0] captured, last;
  logic                  valid, mismatch, capture, do_latch, busy_next;
  logic [BCD_W-1:0]      digits, result;
  logic [REF_W-1:0]      refresh;
  logic [1:0]            scan;
  logic [3:0]            cur_nibble, select;
  logic                  cur_blank;
  logic [6:0]            pattern;

  // Reconvert on any new value, and always once after reset.
  assign mismatch = !valid || (dataIn != last);

`ifdef SEVEN_SEG_DECIMAL_EN
  localparam int ITER_W = $clog2(DATA_WIDTH) + 1;
  logic [DATA_WIDTH-1:0] shreg;
  logic [BCD_W-1:0]      bcd;
  logic [ITER_W-1:0]     iter;
  assign result = bcd;
`else
  assign result = BCD_W'(captured);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (mismatch) begin
`ifdef SEVEN_SEG_DECIMAL_EN
          state_next = ADD3;
`else
          state_next = LATCH;
`endif
        end else begin
          state_next = IDLE;
        end
      end
`ifdef SEVEN_SEG_DECIMAL_EN
      ADD3: state_next = SHIFT;
      SHIFT: begin
        if (iter == ITER_W'(DATA_WIDTH - 1)) begin
          state_next = LATCH;
        end else begin
          state_next = ADD3;
        end
      end
`endif
      LATCH:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    capture   = (state == IDLE) && mismatch;
    do_latch  = (state == LATCH);
    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy     <= 1'b0;
      valid    <= 1'b0;
      last     <= '0;
      captured <= '0;
      digits   <= '0;
    end else begin
      busy <= busy_next;
      if (capture) begin
        captured <= dataIn;
      end
      if (do_latch) begin
        digits <= result;
        last   <= captured;
        valid  <= 1'b1;
      end
    end
  end

`ifdef SEVEN_SEG_DECIMAL_EN
  // Double-dabble datapath: add-3 correction then shift, one bit per pair of cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg <= '0;
      bcd   <= '0;
      iter  <= '0;
    end else if (capture) begin
      shreg <= dataIn;
      bcd   <= '0;
      iter  <= '0;
    end else if (state == ADD3) begin
      bcd <= bcd_add3(bcd);
    end else if (state == SHIFT) begin
      {bcd, shreg} <= {bcd[BCD_W-2:0], shreg, 1'b0};
      iter         <= iter + ITER_W'(1);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      refresh <= '0;
      scan    <= 2'd0;
    end else if (refresh == REF_W'(REFRESH_TARGET - 1)) begin
      refresh <= '0;
      scan    <= scan + 2'd1;
    end else begin
      refresh <= refresh + REF_W'(1);
    end
  end

  always_comb begin
    cur_nibble = digits[{scan, 2'b00} +: 4];
    select     = 4'b0001 << scan;
    case (scan)
`ifdef SEVEN_SEG_DECIMAL_EN
      2'd0:    cur_blank = 1'b0;
      2'd1:    cur_blank = (digits[11:4] == 8'd0);
      2'd2:    cur_blank = (digits[11:8] == 4'd0);
      default: cur_blank = 1'b1;
`else
      2'd0, 2'd1: cur_blank = 1'b0;
      default:    cur_blank = 1'b1;
`endif
    endcase
  end

  seg_decoder u_dec (
    .nibble (cur_nibble),
    .blank  (cur_blank),
    .seg    (pattern)
  );

  // Anode and segments come from the same scan index on the same edge, so they never disagree.
  always_ff @(posedge clk) begin
    if (reset) begin
      segOut   <= GLYPH_0 ^ SEG_MASK;
      anodeOut <= 4'b0001 ^ ANODE_MASK;
    end else begin
      segOut   <= pattern ^ SEG_MASK;
      anodeOut <= select ^ ANODE_MASK;
    end
  end

endmodule

// File: tb/tb_seven_seg_driver.sv
// Scoreboard bench: stimulus queues expected busy lengths and display frames,
// a negedge monitor checks busy pulses and every scan step against them.
module tb_seven_seg_driver;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] dataIn;
  logic [6:0] segOut;
  logic [3:0] anodeOut;
  logic       busy;

  int tests = 0;
  int fails = 0;
  int busy_q[$];
  logic [19:0] frame_q[$];
  int pulses = 0, total_busy = 0, bcnt = 0, fhits = 0, ivl = 0;
  bit first = 1'b1;
  logic [3:0] prev_anode;

`ifdef SEVEN_SEG_DECIMAL_EN
  localparam int CONV = 17;
`else
  localparam int CONV = 1;
`endif
  localparam logic [4:0] BL = 5'd16;

  seven_seg_driver #(.DATA_WIDTH(8), .REFRESH_TARGET(4), .SEG_ACTIVE_LOW(1)) dut (
    .clk(clk), .reset(reset), .dataIn(dataIn),
    .segOut(segOut), .anodeOut(anodeOut), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] glyph(input logic [4:0] c);
    case (c)
      5'd0: return 7'h3F;  5'd1: return 7'h06;  5'd2: return 7'h5B;  5'd3: return 7'h4F;
      5'd4: return 7'h66;  5'd5: return 7'h6D;  5'd6: return 7'h7D;  5'd7: return 7'h07;
      5'd8: return 7'h7F;  5'd9: return 7'h6F;  5'd10: return 7'h77; 5'd11: return 7'h7C;
      5'd12: return 7'h39; 5'd13: return 7'h5E; 5'd14: return 7'h79; 5'd15: return 7'h71;
      default: return 7'h00;
    endcase
  endfunction

  // Hand-computed digit codes {d3,d2,d1,d0}; BL = blank.
  function automatic logic [19:0] frame_of(input int v);
`ifdef SEVEN_SEG_DECIMAL_EN
    case (v)
      0:   return {BL, BL, BL, 5'd0};
      255: return {BL, 5'd2, 5'd5, 5'd5};
      7:   return {BL, BL, BL, 5'd7};
      10:  return {BL, BL, 5'd1, 5'd0};
      60:  return {BL, BL, 5'd6, 5'd0};
      88:  return {BL, BL, 5'd8, 5'd8};
      129: return {BL, 5'd1, 5'd2, 5'd9};
      155: return {BL, 5'd1, 5'd5, 5'd5};
      222: return {BL, 5'd2, 5'd2, 5'd2};
      42:  return {BL, BL, 5'd4, 5'd2};
      200: return {BL, 5'd2, 5'd0, 5'd0};
      default: return {BL, BL, BL, BL};
    endcase
`else
    case (v)
      0:   return {BL, BL, 5'd0, 5'd0};
      255: return {BL, BL, 5'd15, 5'd15};
      7:   return {BL, BL, 5'd0, 5'd7};
      10:  return {BL, BL, 5'd0, 5'd10};
      60:  return {BL, BL, 5'd3, 5'd12};
      88:  return {BL, BL, 5'd5, 5'd8};
      129: return {BL, BL, 5'd8, 5'd1};
      155: return {BL, BL, 5'd9, 5'd11};
      222: return {BL, BL, 5'd13, 5'd14};
      42:  return {BL, BL, 5'd2, 5'd10};
      200: return {BL, BL, 5'd12, 5'd8};
      default: return {BL, BL, BL, BL};
    endcase
`endif
  endfunction

  // Monitor: busy pulse lengths and every anode step against the queued frame.
  always @(negedge clk) begin
    int idx;
    logic [19:0] fr;
    logic [6:0] es;
    logic [3:0] ea;
    if (reset) begin
      bcnt = 0;
      first = 1'b1;
      ivl = 0;
      prev_anode = anodeOut;
    end else begin
      if (busy) begin
        bcnt++;
        total_busy++;
      end else if (bcnt > 0) begin
        pulses++;
        if (busy_q.size() == 0) check("unexpected_busy", bcnt, 0);
        else check("busy_len", bcnt, busy_q.pop_front());
        bcnt = 0;
      end
      ivl++;
      if (anodeOut !== prev_anode) begin
        ea = {prev_anode[2:0], prev_anode[3]};
        check("scan_order", anodeOut, ea);
        if (!first) check("scan_interval", ivl, 4);
        first = 1'b0;
        ivl = 0;
        if (frame_q.size() > 0) begin
          case (anodeOut)
            4'b1110: idx = 0;
            4'b1101: idx = 1;
            4'b1011: idx = 2;
            4'b0111: idx = 3;
            default: idx = -1;
          endcase
          check("anode_onehot", int'(idx >= 0), 1);
          if (idx >= 0) begin
            fr = frame_q[0];
            es = ~glyph(fr[5*idx +: 5]);
            check("seg_digit", segOut, es);
          end
          fhits++;
          if (fhits == 4) begin
            void'(frame_q.pop_front());
            fhits = 0;
          end
        end
      end
      prev_anode = anodeOut;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_empty(input string name);
    int k = 0;
    while ((busy_q.size() != 0 || frame_q.size() != 0) && k < 300) begin
      cyc(1);
      k++;
    end
    if (k >= 300) check(name, busy_q.size() + frame_q.size(), 0);
  endtask

  task automatic wait_busy_high(input string name);
    int k = 0;
    while (busy !== 1'b1 && k < 50) begin
      cyc(1);
      k++;
    end
    if (k >= 50) check(name, busy, 1);
  endtask

  task automatic apply(input int v);
    dataIn = 8'(v);
    busy_q.push_back(CONV);
    wait_empty("timeout_conv");
    cyc(2);
    frame_q.push_back(frame_of(v));
    wait_empty("timeout_frame");
  endtask

  initial begin
    int vals[8] = '{255, 7, 10, 60, 88, 129, 155, 222};
    int p0, t0;
    reset = 1'b1;
    dataIn = 8'd0;
    cyc(2);
    check("rst_anode", anodeOut, 4'b1110);
    check("rst_seg", segOut, 7'b1000000);
    check("rst_busy", busy, 0);

    busy_q.push_back(CONV);
    reset = 1'b0;
    wait_empty("timeout_first");
    cyc(2);
    frame_q.push_back(frame_of(0));
    wait_empty("timeout_frame0");

    foreach (vals[i]) apply(vals[i]);

    p0 = pulses;
    cyc(30);
    check("no_reconvert", pulses - p0, 0);

    t0 = total_busy;
    dataIn = 8'd100;
    busy_q.push_back(CONV);
    wait_busy_high("timeout_busy100");
    cyc(4);
    dataIn = 8'd42;
    busy_q.push_back(CONV);
    wait_empty("timeout_change");
    cyc(2);
    check("total_busy", total_busy - t0, 2 * CONV);
    frame_q.push_back(frame_of(42));
    wait_empty("timeout_frame42");

    dataIn = 8'd200;
    busy_q.push_back(CONV);
    wait_busy_high("timeout_busy200");
    cyc((CONV == 17) ? 7 : 0);
    reset = 1'b1;
    busy_q.delete();
    cyc(1);
    check("midrst_busy", busy, 0);
    check("midrst_anode", anodeOut, 4'b1110);
    check("midrst_seg", segOut, 7'b1000000);
    cyc(1);
    busy_q.push_back(CONV);
    reset = 1'b0;
    wait_empty("timeout_post_rst");
    cyc(2);
    frame_q.push_back(frame_of(200));
    wait_empty("timeout_frame200");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seven_seg_driver.md
SEVEN_SEG_DRIVER -- requirements
Module: seven_seg_driver

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the width of the value to display.
REQ-002 The block SHALL have parameter REFRESH_TARGET, default 1000, giving the clk cycles each digit is lit per scan slot.
REQ-003 The block SHALL have parameter SEG_ACTIVE_LOW, default 1; when 1, segOut and anodeOut are active-low.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock. All state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port dataIn, input, DATA_WIDTH bits: the value to display, driven by the CPU output register cpuOut.
REQ-007 The block SHALL have port segOut, output, 7 bits: segments {g,f,e,d,c,b,a} of the lit digit, registered.
REQ-008 The block SHALL have port anodeOut, output, 4 bits: one-hot digit select, bit0 = rightmost digit, registered.
REQ-009 The block SHALL have port busy, output, 1 bit: high while a conversion is in progress.

Function
REQ-010 The conversion FSM SHALL have the states IDLE, ADD3, SHIFT and LATCH.
REQ-011 In IDLE, when dataIn differs from the last latched value or the value is invalid, the FSM SHALL capture dataIn into the shift register, clear the BCD field, set iter=0 and go to ADD3.
REQ-012 In ADD3, every BCD nibble >= 5 SHALL get +3, then the FSM SHALL go to SHIFT.
REQ-013 In SHIFT, {bcd,bin} SHALL shift left 1 and iter SHALL increment; at iter==DATA_WIDTH-1 the FSM SHALL go to LATCH, otherwise back to ADD3.
REQ-014 In LATCH, the digit registers SHALL load the BCD result, the last latched value SHALL load the captured value, valid SHALL be set, and the FSM SHALL return to IDLE.
REQ-015 Latency: for DATA_WIDTH=8, the digit registers SHALL update on the 17th edge after the capture edge; busy SHALL be high for exactly those 17 cycles.
REQ-016 dataIn changes during a conversion SHALL be ignored until IDLE; a mismatch is then detected and the block SHALL reconvert. No value is lost and the last value always wins.
REQ-017 Leading-zero blanking: a leading-zero digit SHALL show the blank glyph; the units digit SHALL never be blanked; digit3 SHALL always be blank in decimal mode.
REQ-018 Scan: the refresh counter SHALL count 0..REFRESH_TARGET-1; at the terminal count it SHALL wrap to 0 and the scan index SHALL advance 0->1->2->3->0.
REQ-019 segOut and anodeOut SHALL update one cycle after a scan-index or digit-register change. There SHALL be no glitch between the anode and its segment pattern.
REQ-020 A conversion and a scan step in the same cycle SHALL proceed independently; the lit digit SHALL show the old digit value until LATCH.

Reset
REQ-021 While reset is high, the block SHALL set: FSM=IDLE, busy=0, valid=0, digit regs=0, refresh counter=0, scan index=0.
REQ-022 While reset is high, anodeOut SHALL select digit0 and segOut SHALL show glyph '0'.
REQ-023 Reset mid-conversion SHALL abort the conversion. After reset, the first cycle SHALL start a conversion of dataIn, because valid=0.

Configuration
REQ-024 With SEVEN_SEG_DECIMAL_EN defined, the block SHALL use decimal mode via the double-dabble FSM: 0..255 on digits 2..0.
REQ-025 Without SEVEN_SEG_DECIMAL_EN, the block SHALL use hex mode:
- the ADD3/SHIFT states are removed; IDLE on mismatch goes directly to LATCH, so busy is high for 1 cycle;
- digits 1..0 show the nibbles of dataIn with no blanking;
- digits 3..2 are blank.

Structure
REQ-026 Package aeolus_display_pkg SHALL hold:
- the FSM state typedef;
- NUM_DIGITS=4;
- glyph constants 0-F and BLANK, stored active-high; polarity is applied at the output.
REQ-027 Sub-module seg_decoder SHALL be combinational and map a nibble plus a blank flag to a 7-bit active-high pattern.

Verification
REQ-028 Reset 2 cycles with dataIn=0, SEG_ACTIVE_LOW=1 -> anodeOut=4'b1110, segOut=7'b1000000, busy=0.
REQ-029 Decimal mode, dataIn=255 -> busy high for 17 cycles; digits show 2,5,5 and digit3 is blank.
REQ-030 Decimal mode, dataIn=7 -> digit0 segOut=7'b1111000, digits 1-3 blank.
REQ-031 dataIn 100 -> 42 at cycle 5 of a conversion -> 100 is latched first, then a second conversion runs; the final display is 42, with 34 busy cycles in total.
REQ-032 REFRESH_TARGET=4 -> anodeOut sequence 1110, 1101, 1011, 0111, 1110, changing every 4 cycles.
REQ-033 Reset asserted at cycle 8 of a conversion of 200 -> busy=0 and digits=0; after release, 200 is converted and displayed.
